hg_round_ctrl: RTL and testbench

- Central game sequencer for the two-player Halli Galli design.
- Decodes player flip/bell pulses, enforces turn order, and requests cards from the card generator with a req/ack handshake.
- Arbitrates bell presses, judges them using the `right` flag from the correctness checker, and maintains both scores and the shared pile count.
- Declares the winner; drives the LED/segment/LCD path through `whose`, the scores and `winner`.

---
 rtl/hg_round_ctrl_pkg.sv | 43 ++++
 rtl/hg_round_ctrl_bell_arb.sv | 36 +++
 rtl/hg_round_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_hg_round_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hg_round_ctrl_pkg.sv
// Shared definitions for the Halli Galli round controller.
//   hg_state_t   : sequencer states
//   PLAYER_1/2   : single-bit player identifiers (whose, pusher)
//   CODE_*       : two-bit one-hot codes used by bell_who and winner
//   sat_add/dec  : saturating score arithmetic on 32-bit containers
package hg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_FLIP,
    DEAL,
    OPEN,
    JUDGE,
    CHECK,
    DONE
  } hg_state_t;

  localparam logic PLAYER_1 = 1'b0;
  localparam logic PLAYER_2 = 1'b1;

  localparam logic [1:0] CODE_NONE = 2'b00;
  localparam logic [1:0] CODE_P1   = 2'b01;
  localparam logic [1:0] CODE_P2   = 2'b10;

  function automatic logic [1:0] player_code(input logic p);
    return (p == PLAYER_2) ? CODE_P2 : CODE_P1;
  endfunction

  // Add clamped at max_val; one spare bit catches the carry.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] max_val);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (sum > {1'b0, max_val}) ? max_val : sum[31:0];
  endfunction

  // Decrement floored at zero.
  function automatic logic [31:0] sat_dec(input logic [31:0] a);
    return (a == '0) ? '0 : a - 32'd1;
  endfunction

endpackage

// File: rtl/hg_round_ctrl_bell_arb.sv
// Two-input bell arbiter with a toggling priority bit.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : arbitration enabled (bells outside the window are dropped)
//   req1, req2 : P1 / P2 bell pulses
//   gnt        : a bell is granted this cycle
//   gnt_id     : granted player (PLAYER_1 / PLAYER_2)
module bell_arb
  import hg_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic req1,
  input  logic req2,
  output logic gnt,
  output logic gnt_id
);

  logic prio;

  always_comb begin
    gnt    = en & (req1 | req2);
    gnt_id = (req1 & req2) ? prio : req2;
  end

  // Priority only moves on a real collision so single presses never
  // disturb the fairness order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio <= PLAYER_1;
    end else if (en && req1 && req2) begin
      prio <= ~prio;
    end
  end

endmodule

// File: rtl/hg_round_ctrl.sv
// Central game sequencer for the two-player Halli Galli design.
//   clk, rst          : clock, asynchronous active-low reset
//   flip1/2, bell1/2  : player pulses
//   right             : table satisfies the bell rule (valid with cards_valid)
//   deal_ack/deal_req : card generator handshake
//   whose             : current turn (0=P1, 1=P2)
//   cards_valid       : a card is on the table since the last clear
//   pile_cnt          : cards on the table
//   score_a/score_b   : player scores
//   bell_who          : last granted bell (01=P1, 10=P2)
//   winner            : 00 none, 01 P1, 10 P2
//   finish            : one-cycle pulse after each judge
module hg_round_ctrl
  import hg_pkg::*;
#(
  parameter int unsigned WIN_SCORE = 8,
  parameter int unsigned SCORE_W   = 8,
  parameter int unsigned BELL_WIN  = 16,
  parameter int unsigned ACK_TO    = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flip1,
  input  logic               flip2,
  input  logic               bell1,
  input  logic               bell2,
  input  logic               right,
  input  logic               deal_ack,
  output logic               deal_req,
  output logic               whose,
  output logic               cards_valid,
  output logic [SCORE_W-1:0] pile_cnt,
  output logic [SCORE_W-1:0] score_a,
  output logic [SCORE_W-1:0] score_b,
  output logic [1:0]         bell_who,
  output logic [1:0]         winner,
  output logic               finish
);

  localparam int unsigned WIN_W = $clog2(BELL_WIN + 1);
  localparam int unsigned TO_W  = (ACK_TO > 1) ? $clog2(ACK_TO) : 1;

  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
  localparam logic [SCORE_W-1:0] WIN_TH    = SCORE_W'(WIN_SCORE);
  localparam logic [WIN_W-1:0]   WIN_LOAD  = WIN_W'(BELL_WIN);
  localparam logic [WIN_W-1:0]   WIN_ONE   = WIN_W'(1);
  localparam logic [TO_W-1:0]    TO_LAST   = TO_W'(ACK_TO - 1);

  hg_state_t         state;
  logic              pusher;
  logic [WIN_W-1:0]  win_cnt;
  logic [TO_W-1:0]   to_cnt;

  logic arb_en;
  logic arb_gnt;
  logic arb_id;
  logic flip_ok;
  logic judge_right;

  always_comb begin
    arb_en      = (state == WAIT_FLIP) || (state == OPEN);
    flip_ok     = (flip1 && (whose == PLAYER_1)) || (flip2 && (whose == PLAYER_2));
    judge_right = right & cards_valid;
  end

  bell_arb u_bell_arb (
    .clk    (clk),
    .rst_n  (rst),
    .en     (arb_en),
    .req1   (bell1),
    .req2   (bell2),
    .gnt    (arb_gnt),
    .gnt_id (arb_id)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      deal_req    <= 1'b0;
      whose       <= PLAYER_1;
      cards_valid <= 1'b0;
      pile_cnt    <= '0;
      score_a     <= '0;
      score_b     <= '0;
      bell_who    <= CODE_NONE;
      winner      <= CODE_NONE;
      finish      <= 1'b0;
      pusher      <= PLAYER_1;
      win_cnt     <= '0;
      to_cnt      <= '0;
    end else begin
      finish <= 1'b0;
      unique case (state)
        IDLE: state <= WAIT_FLIP;

        WAIT_FLIP: begin
          // A bell wins over a same-cycle flip.
          if (arb_gnt) begin
            pusher   <= arb_id;
            bell_who <= player_code(arb_id);
            state    <= JUDGE;
          end else if (flip_ok) begin
            deal_req <= 1'b1;
            to_cnt   <= '0;
            state    <= DEAL;
          end
        end

        DEAL: begin
          // to_cnt counts high cycles of deal_req; after ACK_TO of them
          // the request is dropped for exactly one cycle and re-raised.
          if (deal_req) begin
            if (deal_ack) begin
              deal_req    <= 1'b0;
              pile_cnt    <= SCORE_W'(sat_add(32'(pile_cnt), 32'd1, 32'(SCORE_MAX)));
              cards_valid <= 1'b1;
              win_cnt     <= WIN_LOAD;
              state       <= OPEN;
            end else if (to_cnt == TO_LAST) begin
              deal_req <= 1'b0;
              to_cnt   <= '0;
            end else begin
              to_cnt <= to_cnt + TO_W'(1);
            end
          end else begin
            deal_req <= 1'b1;
          end
        end

        OPEN: begin
          if (arb_gnt) begin
            pusher   <= arb_id;
            bell_who <= player_code(arb_id);
            state    <= JUDGE;
          end else if (win_cnt <= WIN_ONE) begin
            whose <= ~whose;
            state <= WAIT_FLIP;
          end else begin
            win_cnt <= win_cnt - WIN_ONE;
          end
        end

        JUDGE: begin
          finish <= 1'b1;
          state  <= CHECK;
          if (judge_right) begin
            if (pusher == PLAYER_1) begin
              score_a <= SCORE_W'(sat_add(32'(score_a), 32'(pile_cnt), 32'(SCORE_MAX)));
            end else begin
              score_b <= SCORE_W'(sat_add(32'(score_b), 32'(pile_cnt), 32'(SCORE_MAX)));
            end
            pile_cnt    <= '0;
            cards_valid <= 1'b0;
            whose       <= pusher;
          end else if (pusher == PLAYER_1) begin
            score_a <= SCORE_W'(sat_dec(32'(score_a)));
            score_b <= SCORE_W'(sat_add(32'(score_b), 32'd1, 32'(SCORE_MAX)));
          end else begin
            score_b <= SCORE_W'(sat_dec(32'(score_b)));
            score_a <= SCORE_W'(sat_add(32'(score_a), 32'd1, 32'(SCORE_MAX)));
          end
        end

        CHECK: begin
          if (score_a >= WIN_TH) begin
            winner <= CODE_P1;
            state  <= DONE;
          end else if (score_b >= WIN_TH) begin
            winner <= CODE_P2;
            state  <= DONE;
          end else begin
            state <= WAIT_FLIP;
          end
        end

        DONE: ;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hg_round_ctrl.sv
// Self-checking bench for hg_round_ctrl: directed scenarios followed by
// random play, compared against a game-rule reference model.
module tb_hg_round_ctrl;

  localparam int WIN_SCORE = 8;
  localparam int SCORE_W   = 8;
  localparam int BELL_WIN  = 16;
  localparam int ACK_TO    = 15;
  localparam int SMAX      = (1 << SCORE_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flip1 = 1'b0, flip2 = 1'b0, bell1 = 1'b0, bell2 = 1'b0;
  logic right = 1'b0, deal_ack = 1'b0;
  logic deal_req, whose, cards_valid, finish;
  logic [SCORE_W-1:0] pile_cnt, score_a, score_b;
  logic [1:0] bell_who, winner;

  always #5 clk = ~clk;

  hg_round_ctrl #(
    .WIN_SCORE (WIN_SCORE),
    .SCORE_W   (SCORE_W),
    .BELL_WIN  (BELL_WIN),
    .ACK_TO    (ACK_TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flip1       (flip1),
    .flip2       (flip2),
    .bell1       (bell1),
    .bell2       (bell2),
    .right       (right),
    .deal_ack    (deal_ack),
    .deal_req    (deal_req),
    .whose       (whose),
    .cards_valid (cards_valid),
    .pile_cnt    (pile_cnt),
    .score_a     (score_a),
    .score_b     (score_b),
    .bell_who    (bell_who),
    .winner      (winner),
    .finish      (finish)
  );

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Reference game state
  int m_whose, m_pile, m_sa, m_sb, m_cv, m_bw, m_win, m_prio;
  bit m_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic int sat(input int v);
    return (v > SMAX) ? SMAX : v;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".whose"},  32'(whose),       m_whose);
    chk({tag, ".pile"},   32'(pile_cnt),    m_pile);
    chk({tag, ".sa"},     32'(score_a),     m_sa);
    chk({tag, ".sb"},     32'(score_b),     m_sb);
    chk({tag, ".cv"},     32'(cards_valid), m_cv);
    chk({tag, ".bw"},     32'(bell_who),    m_bw);
    chk({tag, ".win"},    32'(winner),      m_win);
    chk({tag, ".req"},    32'(deal_req),    0);
    chk({tag, ".finish"}, 32'(finish),      0);
  endtask

  // Reset asserted asynchronously between edges; released and IDLE passed.
  task automatic do_reset();
    #2;
    rst = 1'b0;
    flip1 = 0; flip2 = 0; bell1 = 0; bell2 = 0; right = 0; deal_ack = 0;
    #1;
    m_whose = 0; m_pile = 0; m_sa = 0; m_sb = 0; m_cv = 0;
    m_bw = 0; m_win = 0; m_prio = 0; m_done = 0;
    check_all("reset");
    tick();
    rst = 1'b1;
    tick();
  endtask

  // Flip from player p (0/1) while waiting for a flip; ok tells if accepted.
  task automatic do_flip(input int p, output bit ok);
    ok = (p == m_whose);
    if (p == 0) flip1 = 1'b1; else flip2 = 1'b1;
    tick();
    flip1 = 1'b0; flip2 = 1'b0;
    chk("flip_req", 32'(deal_req), ok ? 1 : 0);
  endtask

  task automatic do_deal(input int delay);
    for (int i = 0; i < delay; i++) begin
      chk("req_held", 32'(deal_req), 1);
      tick();
    end
    deal_ack = 1'b1;
    tick();
    deal_ack = 1'b0;
    m_pile = sat(m_pile + 1);
    m_cv = 1;
    chk("ack_req", 32'(deal_req), 0);
    chk("ack_pile", 32'(pile_cnt), m_pile);
    chk("ack_cv", 32'(cards_valid), 1);
  endtask

  // Window runs out with no bell; optional stray flips must be ignored.
  task automatic do_expire(input bit noisy);
    for (int i = 0; i < BELL_WIN; i++) begin
      if (i == BELL_WIN - 1) chk("win_last", 32'(whose), m_whose);
      if (noisy && $urandom_range(0, 2) == 0) begin
        if ($urandom_range(0, 1) == 0) flip1 = 1'b1; else flip2 = 1'b1;
      end
      tick();
      flip1 = 1'b0; flip2 = 1'b0;
    end
    m_whose ^= 1;
    chk("expire_whose", 32'(whose), m_whose);
    chk("expire_req", 32'(deal_req), 0);
  endtask

  // sel: 1=bell1, 2=bell2, 3=both
  task automatic do_bell(input int sel, input bit r);
    int g;
    bell1 = sel[0];
    bell2 = sel[1];
    right = r;
    tick();
    bell1 = 1'b0; bell2 = 1'b0;
    if (sel == 3) begin
      g = m_prio;
      m_prio ^= 1;
    end else begin
      g = (sel == 2) ? 1 : 0;
    end
    m_bw = (g == 1) ? 2 : 1;
    chk("bell_who", 32'(bell_who), m_bw);
    chk("judge_finish0", 32'(finish), 0);
    tick();
    right = 1'b0;
    if (r && m_cv == 1) begin
      if (g == 0) m_sa = sat(m_sa + m_pile); else m_sb = sat(m_sb + m_pile);
      m_pile = 0;
      m_cv = 0;
      m_whose = g;
    end else if (g == 0) begin
      m_sa = (m_sa > 0) ? m_sa - 1 : 0;
      m_sb = sat(m_sb + 1);
    end else begin
      m_sb = (m_sb > 0) ? m_sb - 1 : 0;
      m_sa = sat(m_sa + 1);
    end
    chk("j_sa", 32'(score_a), m_sa);
    chk("j_sb", 32'(score_b), m_sb);
    chk("j_pile", 32'(pile_cnt), m_pile);
    chk("j_cv", 32'(cards_valid), m_cv);
    chk("j_whose", 32'(whose), m_whose);
    chk("j_finish", 32'(finish), 1);
    tick();
    if (m_sa >= WIN_SCORE) m_win = 1;
    else if (m_sb >= WIN_SCORE) m_win = 2;
    m_done = (m_win != 0);
    chk("c_winner", 32'(winner), m_win);
    chk("c_finish", 32'(finish), 0);
  endtask

  task automatic done_probe();
    flip1 = 1'b1; tick(); flip1 = 1'b0;
    flip2 = 1'b1; tick(); flip2 = 1'b0;
    bell1 = 1'b1; bell2 = 1'b1; right = 1'b1; tick();
    bell1 = 1'b0; bell2 = 1'b0; right = 1'b0;
    bell2 = 1'b1; tick(); bell2 = 1'b0;
    deal_ack = 1'b1; tick(); deal_ack = 1'b0;
    check_all("done_hold");
  endtask

  initial begin
    bit ok;
    int act, sel, w;

    // Reset and first deal
    do_reset();
    check_all("post_reset");
    do_flip(1, ok);
    do_flip(0, ok);
    do_deal(3);

    // Three windows expire: turn alternates, pile grows to 3
    do_expire(1'b1);
    do_flip(1, ok);
    do_deal(0);
    do_expire(1'b0);
    do_flip(0, ok);
    do_deal(ACK_TO - 1);
    do_expire(1'b1);
    check_all("three_cards");

    // Correct bell2 takes the pile; then a wrong bell1 with a floored score
    do_bell(2, 1'b1);
    do_bell(1, 1'b0);

    // Collisions alternate the grant
    do_bell(3, 1'b0);
    do_bell(3, 1'b0);
    check_all("after_collide");

    // Handshake timeout, then reset in the middle of a request
    do_flip(m_whose, ok);
    for (int k = 0; k < ACK_TO; k++) begin
      if (k != 0) tick();
      chk("to_high", 32'(deal_req), 1);
    end
    tick();
    chk("to_drop", 32'(deal_req), 0);
    tick();
    chk("to_rearm", 32'(deal_req), 1);
    do_reset();

    // Drive score_a to 7 with wrong P2 bells, then win with a pile of 2
    for (int k = 0; k < 7; k++) do_bell(2, 1'b0);
    do_flip(0, ok);
    do_deal(1);
    do_expire(1'b0);
    do_flip(1, ok);
    do_deal(2);
    repeat (5) tick();
    do_bell(1, 1'b1);
    chk("win_sa9", 32'(score_a), 9);
    done_probe();

    // Random play
    do_reset();
    for (int it = 0; it < 80; it++) begin
      if (m_done) begin
        done_probe();
        do_reset();
      end
      act = $urandom_range(0, 5);
      sel = $urandom_range(1, 3);
      if (act == 0) begin
        do_flip(m_whose ^ 1, ok);
      end else if (act == 1) begin
        do_bell(sel, 1'($urandom_range(0, 1)));
      end else begin
        do_flip(m_whose, ok);
        do_deal($urandom_range(0, ACK_TO - 1));
        if ($urandom_range(0, 2) == 0) begin
          do_expire(1'b1);
        end else begin
          w = $urandom_range(0, BELL_WIN - 1);
          repeat (w) tick();
          do_bell(sel, 1'($urandom_range(0, 1)));
        end
      end
      if (!m_done) check_all("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
